// File: rtl/risc_fetch.sv
// Instruction fetch: owns the PC, addresses the ROM, latches the word into an IR for decode; resolves GOTO locally.
// Latency: rom_addr -> IR in one cycle, one instruction per cycle, GOTO target fetched with no bubble.
// Backpressure: IR holds while out_valid && !out_ready; redirect flushes the IR regardless of run/out_ready.
module risc_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  GOTO_OPCODE = 6'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_jump,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic        advance;
    logic        fetch_is_jump;
    logic [31:0] seq_pc;
    logic [31:0] jump_ofs;
    logic [31:0] next_pc;

    assign rom_addr = pc;

    // The IR slot is free when empty or being consumed this same cycle.
    assign advance       = run && (!out_valid || out_ready);
    assign fetch_is_jump = (rom_data[31:26] == GOTO_OPCODE);
    assign seq_pc        = pc + 32'd4;

    // Signed 26-bit word offset, scaled to bytes, relative to the sequential PC.
    assign jump_ofs = {{4{rom_data[25]}}, rom_data[25:0], 2'b00};
    assign next_pc  = fetch_is_jump ? (seq_pc + jump_ofs) : seq_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            out_is_jump <= 1'b0;
            fetch_count <= 32'h0;
        end else if (redirect_valid) begin
            pc        <= redirect_target & ~32'h3;
            out_valid <= 1'b0;
        end else if (advance) begin
            pc          <= next_pc;
            out_valid   <= 1'b1;
            out_instr   <= rom_data;
            out_pc      <= pc;
            out_is_jump <= fetch_is_jump;
            fetch_count <= fetch_count + 32'd1;
        end else if (out_ready) begin
            // Draining with run low: decode takes the IR, nothing refills it.
            out_valid <= 1'b0;
        end
    end

endmodule
